// File: rtl/fb_ram_arbiter_pkg.sv
// Shared types for the frame-buffer RAM arbiter.
// Grant encoding and read-return tag layout.
package fb_pkg;

  localparam int DEF_ADDR_W       = 12;
  localparam int DEF_DATA_W       = 12;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_SCAN = 2'd1,
    G_HOST = 2'd2
  } grant_e;

  typedef enum logic {
    OWN_SCAN = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   bank;
  } tag_t;

endpackage

// File: rtl/fb_ram_arbiter_if.sv
// Scan and host request/response bundle.
// Names are from the arbiter's point of view.
interface fb_ram_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] i_scan_addr;
  logic              i_scan_stb;
  logic              o_scan_ready;
  logic              o_scan_valid;
  logic [DATA_W-1:0] o_scan_b1_data;
  logic [DATA_W-1:0] o_scan_b2_data;

  logic              i_host_req;
  logic              i_host_we;
  logic              i_host_bank;
  logic [ADDR_W-1:0] i_host_addr;
  logic [DATA_W-1:0] i_host_wdata;
  logic              o_host_ack;
  logic [DATA_W-1:0] o_host_rdata;

  modport master (
    output i_scan_addr, i_scan_stb,
    input  o_scan_ready, o_scan_valid,
    input  o_scan_b1_data, o_scan_b2_data,
    output i_host_req, i_host_we, i_host_bank,
    output i_host_addr, i_host_wdata,
    input  o_host_ack, o_host_rdata
  );

  modport slave (
    input  i_scan_addr, i_scan_stb,
    output o_scan_ready, o_scan_valid,
    output o_scan_b1_data, o_scan_b2_data,
    input  i_host_req, i_host_we, i_host_bank,
    input  i_host_addr, i_host_wdata,
    output o_host_ack, o_host_rdata
  );

endinterface

// File: rtl/fb_ram_arbiter_swapper.sv
// Double-buffer page swapper.
// Front page toggles only on a frame boundary.
module fb_page_swapper (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_swap_req,
  input  logic i_frame_end,
  output logic o_swap_pending,
  output logic o_swap_done,
  output logic o_front_page
);

  logic r_pend;
  logic r_done;
  logic r_front;

  // Latch one swap request, execute it at frame end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
      r_front <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_frame_end && (r_pend || i_swap_req)) begin
        r_front <= ~r_front;
        r_pend  <= 1'b0;
        r_done  <= 1'b1;
      end else if (i_swap_req) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign o_swap_pending = r_pend;
  assign o_swap_done    = r_done;
  assign o_front_page   = r_front;

endmodule

// File: rtl/fb_ram_arbiter.sv
// Single-port frame-buffer arbiter: scan vs host,
// with starvation guard and page double-buffering.
module fb_ram_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fb_ram_arbiter_if.slave   bus,
  input  logic              i_frame_end,
  input  logic              i_swap_req,
  output logic              o_swap_pending,
  output logic              o_swap_done,
  output logic              o_front_page,
  output logic [ADDR_W:0]   o_ram_addr,
  output logic              o_ram_re,
  output logic              o_ram_we_b1,
  output logic              o_ram_we_b2,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_b1_data,
  input  logic [DATA_W-1:0] i_ram_b2_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(STARVE_LIMIT);

  grant_e            r_state;
  grant_e            w_gnt;
  logic [CNT_W-1:0]  r_wait;
  logic              r_host_busy;
  logic [ADDR_W:0]   r_addr;
  logic              r_we;
  logic              r_bank;
  logic [DATA_W-1:0] r_wdata;
  tag_t              w_tag1;
  tag_t              r_tag2;
  logic              w_front;
  logic              w_host_pend;
  logic              w_force;
  logic              w_scan_op;
  logic              w_host_op;
  logic              w_wr_ack;
  logic              w_rd_ack;
  logic              w_scan_vld;

  fb_page_swapper u_swap (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_swap_req     (i_swap_req),
    .i_frame_end    (i_frame_end),
    .o_swap_pending (o_swap_pending),
    .o_swap_done    (o_swap_done),
    .o_front_page   (w_front)
  );

  assign o_front_page = w_front;

  // Grant decision: forced host, then scan, then host
  always_comb begin
    w_host_pend = bus.i_host_req & ~r_host_busy;
    w_force     = w_host_pend & (r_wait == LIMIT);
    w_gnt       = G_IDLE;
    if (w_force)
      w_gnt = G_HOST;
    else if (bus.i_scan_stb)
      w_gnt = G_SCAN;
    else if (w_host_pend)
      w_gnt = G_HOST;
  end

  // Register the grant and the page-tagged access
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= G_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_bank  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_gnt;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_bank  <= 1'b0;
      r_wdata <= '0;
      unique case (w_gnt)
        G_SCAN: r_addr <= {w_front, bus.i_scan_addr};
        G_HOST: begin
          r_addr  <= {~w_front, bus.i_host_addr};
          r_we    <= bus.i_host_we;
          r_bank  <= bus.i_host_bank;
          r_wdata <= bus.i_host_we ?
                     bus.i_host_wdata : '0;
        end
        default: ;
      endcase
    end
  end

  // Host outstanding flag and starvation counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_host_busy <= 1'b0;
      r_wait      <= '0;
    end else begin
      if (w_gnt == G_HOST)
        r_host_busy <= 1'b1;
      else if (bus.o_host_ack)
        r_host_busy <= 1'b0;
      if (w_gnt == G_HOST)
        r_wait <= '0;
      else if (w_host_pend && r_wait != LIMIT)
        r_wait <= r_wait + 1'b1;
    end
  end

  assign w_scan_op   = (r_state == G_SCAN);
  assign w_host_op   = (r_state == G_HOST);
  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_ram_re    = w_scan_op | (w_host_op & ~r_we);
  assign o_ram_we_b1 = w_host_op & r_we & ~r_bank;
  assign o_ram_we_b2 = w_host_op & r_we & r_bank;
  assign w_wr_ack    = w_host_op & r_we;

  // Stage-1 tag travels with the RAM read enable
  always_comb begin
    w_tag1.vld   = o_ram_re;
    w_tag1.owner = w_scan_op ? OWN_SCAN : OWN_HOST;
    w_tag1.bank  = r_bank;
  end

  // Stage-2 tag lines up with RAM read data
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_tag2 <= '0;
    else
      r_tag2 <= w_tag1;
  end

  assign w_rd_ack   = r_tag2.vld &
                      (r_tag2.owner == OWN_HOST);
  assign w_scan_vld = r_tag2.vld &
                      (r_tag2.owner == OWN_SCAN);

  assign bus.o_scan_ready   = i_rst & ~w_force;
  assign bus.o_scan_valid   = w_scan_vld;
  assign bus.o_scan_b1_data = w_scan_vld ?
                              i_ram_b1_data : '0;
  assign bus.o_scan_b2_data = w_scan_vld ?
                              i_ram_b2_data : '0;
  assign bus.o_host_ack     = w_wr_ack | w_rd_ack;
  assign bus.o_host_rdata   = !w_rd_ack ? '0 :
                              r_tag2.bank ?
                              i_ram_b2_data :
                              i_ram_b1_data;

endmodule

// File: doc/fb_ram_arbiter.md
Name: fb_ram_arbiter

Overview:
- Owns the dual-bank frame-buffer RAM (bank b1 = upper half-panel, bank b2 = lower half-panel).
- Arbitrates one RAM port between two requesters:
  - the panel scan engine: reads, normally high priority;
  - the host/SoC port: reads and writes, with a starvation guard.
- Implements double buffering: the scan side reads the front page, the host side accesses the back page.
- Swaps pages only at a frame boundary so a frame never tears.

Parameters:
- ADDR_W, 12, per-page word address width (scan/host address, excluding page bit)
- DATA_W, 12, pixel word width (4 bits each of R, G, B)
- STARVE_LIMIT, 8, cycles a pending host request may lose to scan before it is forced through

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_scan_addr  in  ADDR_W  scan read address within front page
- i_scan_stb  in  1  scan read request
- o_scan_ready  out  1  scan request accepted this cycle when i_scan_stb & o_scan_ready
- o_scan_valid  out  1  scan read data valid
- o_scan_b1_data  out  DATA_W  bank b1 read data
- o_scan_b2_data  out  DATA_W  bank b2 read data
- i_host_req  in  1  host request; held until o_host_ack
- i_host_we  in  1  1 = write, 0 = read
- i_host_bank  in  1  0 = b1, 1 = b2
- i_host_addr  in  ADDR_W  host address within back page
- i_host_wdata  in  DATA_W  host write data
- o_host_ack  out  1  one-cycle completion pulse
- o_host_rdata  out  DATA_W  host read data, valid with o_host_ack on reads
- i_frame_end  in  1  one-cycle pulse from scan controller at last row of a frame
- i_swap_req  in  1  one-cycle pulse requesting page swap
- o_swap_pending  out  1  swap requested, not yet executed
- o_swap_done  out  1  one-cycle pulse when front page toggles
- o_front_page  out  1  current front page
- o_ram_addr  out  ADDR_W+1  {page, addr} to both banks
- o_ram_re  out  1  read enable to both banks
- o_ram_we_b1  out  1  write enable bank b1
- o_ram_we_b2  out  1  write enable bank b2
- o_ram_wdata  out  DATA_W  write data
- i_ram_b1_data  in  DATA_W  bank b1 synchronous read data (1-cycle latency)
- i_ram_b2_data  in  DATA_W  bank b2 synchronous read data (1-cycle latency)

Behaviour:
- Reset (async, i_rst low):
  - all outputs 0, o_front_page = 0;
  - wait counter 0, swap pending cleared, pipeline tags cleared, host outstanding flag cleared.
  - Reset mid-transaction drops it silently; no ack is issued.
- Grant decision in cycle N is combinational on requests; RAM controls are registered and drive in N+1.
- Grant FSM per cycle: G_IDLE / G_SCAN / G_HOST.
  - force = host_req & !host_busy & (wait_cnt == STARVE_LIMIT).
  - If force: grant host, o_scan_ready = 0.
  - Else if i_scan_stb: grant scan.
  - Else if host_req & !host_busy: grant host.
  - Else idle.
  - o_scan_ready = !force.
- wait_cnt:
  - increments when host_req & !host_busy & not granted; saturates at STARVE_LIMIT;
  - clears on host grant.
- Scan grant at N:
  - N+1: o_ram_addr = {front_page, i_scan_addr}, o_ram_re = 1;
  - N+2: o_scan_valid = 1, data = i_ram_b*_data.
  - Back-to-back scan grants are allowed every cycle.
- Host write grant at N:
  - N+1: o_ram_addr = {~front_page, addr}, the we of the selected bank = 1, o_host_ack = 1.
- Host read grant at N:
  - N+1: o_ram_re = 1;
  - N+2: o_host_ack = 1, o_host_rdata = selected bank data.
  - host_busy is set from grant until ack, so a held i_host_req is never granted twice.
  - A new request may be granted the cycle after ack.
- A 2-entry tag pipeline (owner, bank) routes each read return. Scan and host returns never coincide because there is one grant per cycle.
- Page is latched at grant time. A host access granted in the same cycle as a swap uses the pre-swap back page.
- Swap:
  - i_swap_req sets o_swap_pending.
  - On i_frame_end with pending (including a same-cycle i_swap_req): toggle o_front_page, clear pending, pulse o_swap_done the next cycle.
  - i_swap_req while already pending is ignored (one swap only).
  - i_frame_end with no pending swap: no effect.
- Scan reads granted before the toggle complete from the old page. Reads granted the cycle after the toggle use the new page.

Decomposition:
- Shared package fb_pkg:
  - ADDR_W/DATA_W defaults;
  - grant encoding (G_IDLE = 0, G_SCAN = 1, G_HOST = 2);
  - tag struct fields (owner, bank).
- One natural sub-module: fb_page_swapper, holding the swap pending/front-page/done logic; the arbiter instantiates it.

Test Plan:
- Scan only: i_scan_stb every cycle, addr 0..47 → o_ram_addr = {0, addr} one cycle later; o_scan_valid two cycles after each stb with RAM-model data; o_scan_ready constantly 1.
- Host write in idle: bank 1, addr 0x123, data 0xABC → next cycle o_ram_we_b2 = 1, o_ram_addr = 0x1123, o_host_ack = 1; host read back returns 0xABC two cycles after grant.
- Starvation: scan stb continuous plus host write held → host granted exactly on the 9th cycle; o_scan_ready = 0 for that one cycle; wait_cnt then 0.
- Swap: i_swap_req at cycle 10, i_frame_end at 50 → o_swap_pending 1 from cycle 11 to 50, o_swap_done at 51, o_front_page = 1; subsequent scan addr bit ADDR_W = 1, host writes to page 0.
- Simultaneous swap_req and frame_end → swap executes that frame; second swap_req while pending → single toggle only.
- Reset asserted with a host read outstanding → all outputs 0 asynchronously; no o_host_ack after release; o_front_page = 0.
